i2s_serializer: RTL and testbench



---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_clk_gen.sv | 55 +++++
 rtl/i2s_serializer.sv | 114 +++++++++++
 tb/tb_i2s_serializer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants for the I2S output stage.
//   Default divider, slot and sample sizes; derived frame length and
//   bit-counter width; channel index constants for the shadow registers.
//   Related build option: I2S_LEFT_JUSTIFIED_EN (handled in i2s_serializer).
package i2s_pkg;

  localparam int DEF_MCLK_HALF = 1;
  localparam int DEF_BCLK_HALF = 4;
  localparam int DEF_SLOT_BITS = 32;
  localparam int DEF_SAMPLE_W  = 24;

  localparam int FRAME_BITS = 2 * DEF_SLOT_BITS;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: free-running mclk and bclk dividers for the I2S stage.
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   mclk       DAC master clock, toggles every MCLK_HALF clk cycles
//   bclk       bit clock, toggles every BCLK_HALF clk cycles
//   bclk_fall  one-cycle enable, high in the cycle whose edge drives bclk 1->0
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int MCLK_HALF = DEF_MCLK_HALF,
  parameter int BCLK_HALF = DEF_BCLK_HALF
) (
  input  logic clk,
  input  logic rst,
  output logic mclk,
  output logic bclk,
  output logic bclk_fall
);

  localparam int MW = cnt_width(MCLK_HALF);
  localparam int BW = cnt_width(BCLK_HALF);

  logic [MW-1:0] mclk_cnt;
  logic [BW-1:0] bclk_cnt;
  logic          bclk_wrap;

  assign bclk_wrap = (bclk_cnt == BW'(BCLK_HALF - 1));
  // Decoded from registers so the consumer updates on the same edge bclk falls.
  assign bclk_fall = bclk_wrap & bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt <= '0;
      bclk_cnt <= '0;
      mclk     <= 1'b0;
      bclk     <= 1'b0;
    end else begin
      if (mclk_cnt == MW'(MCLK_HALF - 1)) begin
        mclk_cnt <= '0;
        mclk     <= ~mclk;
      end else begin
        mclk_cnt <= mclk_cnt + 1'b1;
      end

      if (bclk_wrap) begin
        bclk_cnt <= '0;
        bclk     <= ~bclk;
      end else begin
        bclk_cnt <= bclk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_serializer.sv
// i2s_serializer: stereo 24-bit sample to I2S serial stream for the DAC.
// Ports:
//   clk            system clock (25 MHz)
//   rst            synchronous, active-high reset
//   in_left        signed left sample, held stable by upstream
//   in_right       signed right sample
//   sample_strobe  one-clk pulse in the cycle in_left/in_right are captured
//   mclk, bclk     master and bit clocks
//   lrclk          word select (I2S: 0 = left; left-justified: 1 = left)
//   sdata          serial data, MSB first, changes only as bclk falls
// Build option: define I2S_LEFT_JUSTIFIED_EN for left-justified format
// (no one-bit MSB delay, inverted lrclk, lrclk resets to 1).
module i2s_serializer
  import i2s_pkg::*;
#(
  parameter int MCLK_HALF = DEF_MCLK_HALF,
  parameter int BCLK_HALF = DEF_BCLK_HALF,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int SAMPLE_W  = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                sample_strobe,
  output logic                mclk,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int FRAME_N = 2 * SLOT_BITS;
  localparam int CNT_W   = cnt_width(FRAME_N);
  localparam int IDX_W   = cnt_width(SAMPLE_W);

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam logic LRCLK_RST = 1'b1;
`else
  localparam logic LRCLK_RST = 1'b0;
`endif

  logic                bclk_fall;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] shadow     [2];
  logic [SAMPLE_W-1:0] shadow_nxt [2];
  logic [CNT_W-1:0]    cnt_nxt;
  logic [CNT_W-1:0]    pos;
  logic [CNT_W-1:0]    kpos;
  logic [IDX_W-1:0]    idx;
  logic                capture;
  logic                ch_sel;
  logic                right_slot;
  logic                bit_nxt;

  i2s_clk_gen #(
    .MCLK_HALF (MCLK_HALF),
    .BCLK_HALF (BCLK_HALF)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .mclk      (mclk),
    .bclk      (bclk),
    .bclk_fall (bclk_fall)
  );

  always_comb begin
    cnt_nxt = (bit_cnt == CNT_W'(FRAME_N - 1)) ? '0 : bit_cnt + 1'b1;
    capture = (cnt_nxt == '0);

    // The bit launched with the capture edge must come from the new sample
    // in left-justified mode, so select from the post-capture shadow value.
    shadow_nxt[CH_LEFT]  = capture ? in_left  : shadow[CH_LEFT];
    shadow_nxt[CH_RIGHT] = capture ? in_right : shadow[CH_RIGHT];

`ifdef I2S_LEFT_JUSTIFIED_EN
    pos = cnt_nxt;
`else
    // I2S delays data by one bclk relative to the lrclk edge.
    pos = (cnt_nxt == '0) ? CNT_W'(FRAME_N - 1) : cnt_nxt - 1'b1;
`endif

    ch_sel     = (pos >= CNT_W'(SLOT_BITS));
    kpos       = ch_sel ? pos - CNT_W'(SLOT_BITS) : pos;
    idx        = IDX_W'(SAMPLE_W - 1) - IDX_W'(kpos);
    bit_nxt    = (kpos < CNT_W'(SAMPLE_W)) ? shadow_nxt[ch_sel][idx] : 1'b0;
    right_slot = (cnt_nxt >= CNT_W'(SLOT_BITS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt          <= CNT_W'(FRAME_N - 1);
      shadow[CH_LEFT]  <= '0;
      shadow[CH_RIGHT] <= '0;
      lrclk            <= LRCLK_RST;
      sdata            <= 1'b0;
      sample_strobe    <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (bclk_fall) begin
        bit_cnt          <= cnt_nxt;
        shadow[CH_LEFT]  <= shadow_nxt[CH_LEFT];
        shadow[CH_RIGHT] <= shadow_nxt[CH_RIGHT];
        sample_strobe    <= capture;
        sdata            <= bit_nxt;
`ifdef I2S_LEFT_JUSTIFIED_EN
        lrclk            <= ~right_slot;
`else
        lrclk            <= right_slot;
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2s_serializer.sv
module tb_i2s_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_left;
  logic [23:0] in_right;
  logic        sample_strobe;
  logic        mclk;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  int n_cmp     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int bclk_bad  = 0;
  int mclk_bad  = 0;
  bit mon_en    = 1'b0;
  int strobe_at[$];

  // Frame vectors: bit 63 = first bit after the capture edge (bit_cnt 0).
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam logic        LR_RST = 1'b1;
  localparam logic [63:0] LR_PAT = 64'hFFFFFFFF_00000000;
  localparam logic [63:0] F0_SD  = 64'h80000100_7FFFFE00;
  localparam logic [63:0] F2_SD  = 64'h12345600_7FFFFE00;
  localparam logic [63:0] FR_SD  = 64'hC0000000_00000100;
`else
  localparam logic        LR_RST = 1'b0;
  localparam logic [63:0] LR_PAT = 64'h00000000_FFFFFFFF;
  localparam logic [63:0] F0_SD  = 64'h40000080_3FFFFF00;
  localparam logic [63:0] F2_SD  = 64'h091A2B00_3FFFFF00;
  localparam logic [63:0] FR_SD  = 64'h60000000_00000080;
`endif

  i2s_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .in_left       (in_left),
    .in_right      (in_right),
    .sample_strobe (sample_strobe),
    .mclk          (mclk),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en) begin
      if (bclk !== logic'((cyc >> 2) & 1)) bclk_bad++;
      if (mclk !== logic'(cyc & 1)) mclk_bad++;
    end
    if (sample_strobe === 1'b1) strobe_at.push_back(cyc);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  // Samples sdata/lrclk once per bit while bclk is high (across its rising edge).
  task automatic run_frame(input int f, input bit chg, input logic [23:0] new_left,
                           output logic [63:0] sd, output logic [63:0] lr);
    for (int b = 0; b < 64; b++) begin
      wait_to(512 * f + 8 * b + 12);
      sd[63-b] = sdata;
      lr[63-b] = lrclk;
      if (chg && b == 10) in_left = new_left;
    end
  endtask

  task automatic first_strobe(input string tag);
    int first;
    first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      tick();
      if (sample_strobe === 1'b1) first = cyc;
    end
    chk(tag, 64'(first), 64'd8);
    tick();
    chk({tag, "_width"}, 64'(sample_strobe), 64'd0);
  endtask

  initial begin
    logic [63:0] sd;
    logic [63:0] lr;

    rst      = 1'b1;
    in_left  = 24'h800001;
    in_right = 24'h7FFFFE;
    repeat (5) tick();
    chk("rst_mclk",   64'(mclk),          64'd0);
    chk("rst_bclk",   64'(bclk),          64'd0);
    chk("rst_lrclk",  64'(lrclk),         64'(LR_RST));
    chk("rst_sdata",  64'(sdata),         64'd0);
    chk("rst_strobe", 64'(sample_strobe), 64'd0);

    rst    = 1'b0;
    cyc    = 0;
    mon_en = 1'b1;
    strobe_at.delete();
    first_strobe("first_strobe");

    run_frame(0, 1'b0, 24'h0, sd, lr);
    chk("f0_sdata", sd, F0_SD);
    chk("f0_lrclk", lr, LR_PAT);

    run_frame(1, 1'b1, 24'h123456, sd, lr);
    chk("f1_sdata_old_left", sd, F0_SD);
    chk("f1_lrclk", lr, LR_PAT);

    run_frame(2, 1'b0, 24'h0, sd, lr);
    chk("f2_sdata_new_left", sd, F2_SD);
    chk("f2_lrclk", lr, LR_PAT);

    wait_to(512 * 3 + 8 * 40 + 12);
    mon_en = 1'b0;
    chk("bclk_period_errs", 64'(bclk_bad), 64'd0);
    chk("mclk_period_errs", 64'(mclk_bad), 64'd0);
    chk("strobe_count", 64'(strobe_at.size()), 64'd4);
    if (strobe_at.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk($sformatf("strobe_gap%0d", i), 64'(strobe_at[i] - strobe_at[i-1]), 64'd512);
    end

    rst = 1'b1;
    tick();
    chk("mid_rst_mclk",   64'(mclk),          64'd0);
    chk("mid_rst_bclk",   64'(bclk),          64'd0);
    chk("mid_rst_lrclk",  64'(lrclk),         64'(LR_RST));
    chk("mid_rst_sdata",  64'(sdata),         64'd0);
    chk("mid_rst_strobe", 64'(sample_strobe), 64'd0);

`ifdef I2S_LEFT_JUSTIFIED_EN
    in_left  = 24'hC00000;
`else
    in_left  = 24'hC00000;
`endif
    in_right = 24'h000001;
    rst      = 1'b0;
    cyc      = 0;
    mon_en   = 1'b1;
    first_strobe("restart_strobe");
    run_frame(0, 1'b0, 24'h0, sd, lr);
    chk("restart_sdata", sd, FR_SD);
    chk("restart_lrclk", lr, LR_PAT);
    mon_en = 1'b0;
    chk("restart_bclk_errs", 64'(bclk_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
